hist_eq_div_array: RTL and testbench

- Parametrised successor to the fixed 8-core divider top in the histogram-equalisation pipeline.
- Streams NUM_WORDS packed CDF words from scratch memory and applies the equalisation map to every lane: g = round_down((cdf - cdf_min) * MAXV / (total_pix - cdf_min)).
- Writes packed results back to scratch memory.
- Lane count, widths and address range are generic. Adds a start/busy/done handshake, divide-by-zero detection and saturation.

---
 rtl/hist_eq_div_array_pkg.sv | 26 ++
 rtl/hist_eq_div_array_if.sv | 37 +++
 rtl/hist_eq_div_lane.sv | 62 ++++++
 rtl/hist_eq_div_array.sv | 152 +++++++++++++++
 tb/tb_hist_eq_div_array.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_eq_div_array_pkg.sv
// Shared types and width helpers for the histogram-equalisation divider array.
// HIST_EQ_DIV_ROUND_EN widens the dividend by one bit to hold the rounding offset.
package hist_eq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StLoad,
        StDiv,
        StWr,
        StFin
    } state_e;

    function automatic int unsigned calc_num_w(int unsigned data_w, int unsigned pix_w);
`ifdef HIST_EQ_DIV_ROUND_EN
        return data_w + pix_w + 1;
`else
        return data_w + pix_w;
`endif
    endfunction

    function automatic int unsigned calc_maxv(int unsigned pix_w);
        return (32'd1 << pix_w) - 32'd1;
    endfunction

endpackage

// File: rtl/hist_eq_div_array_if.sv
// Control handshake and scratch-memory bus for hist_eq_div_array.
interface hist_eq_div_array_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);

    logic                      start;
    logic [DATA_W-1:0]         cdf_min;
    logic [DATA_W-1:0]         total_pix;
    logic [ADDR_W-1:0]         rd_base;
    logic [ADDR_W-1:0]         wt_base;
    logic [ADDR_W-1:0]         num_words;
    logic                      busy;
    logic                      done;
    logic                      div_zero_err;

    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic [LANES*DATA_W-1:0]   mem_rd_data;
    logic                      mem_wt_en;
    logic [ADDR_W-1:0]         mem_wt_addr;
    logic [LANES*DATA_W-1:0]   mem_wt_data;

    modport slave (
        input  start, cdf_min, total_pix, rd_base, wt_base, num_words, mem_rd_data,
        output busy, done, div_zero_err, mem_rd_en, mem_rd_addr, mem_wt_en, mem_wt_addr,
               mem_wt_data
    );

    modport master (
        output start, cdf_min, total_pix, rd_base, wt_base, num_words, mem_rd_data,
        input  busy, done, div_zero_err, mem_rd_en, mem_rd_addr, mem_wt_en, mem_wt_addr,
               mem_wt_data
    );

endinterface

// File: rtl/hist_eq_div_lane.sv
// One restoring divider lane: maps a CDF value to an equalised pixel, saturating at MAXV.
// HIST_EQ_DIV_ROUND_EN adds den/2 to the dividend for round-half-up.
module hist_eq_div_lane
    import hist_eq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PIX_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] cdf_i,
    input  logic [DATA_W-1:0] cdf_min_i,
    input  logic [DATA_W-1:0] den_i,
    output logic [PIX_W-1:0]  result_o
);

    localparam int unsigned NumW = calc_num_w(DATA_W, PIX_W);
    localparam int unsigned MaxV = calc_maxv(PIX_W);

    logic [NumW-1:0]   num;
    logic [NumW-1:0]   quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   sub;
    logic [DATA_W:0]   rem_nxt;
    logic              ge;

    always_comb begin
        num = '0;
        if (cdf_i >= cdf_min_i) begin
            num = NumW'(cdf_i - cdf_min_i) * NumW'(MaxV);
        end
`ifdef HIST_EQ_DIV_ROUND_EN
        num = num + NumW'(den_i >> 1);
`endif
    end

    // quo_q starts as the dividend and fills with quotient bits as it shifts left.
    assign trial   = {rem_q, quo_q[NumW-1]};
    assign ge      = trial >= {1'b0, den_i};
    assign sub     = trial - {1'b0, den_i};
    assign rem_nxt = ge ? sub : trial;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= zero_i ? '0 : num;
        end else if (step_i) begin
            rem_q <= DATA_W'(rem_nxt);
            quo_q <= {quo_q[NumW-2:0], ge};
        end
    end

    assign result_o = (quo_q > NumW'(MaxV)) ? PIX_W'(MaxV) : quo_q[PIX_W-1:0];

endmodule

// File: rtl/hist_eq_div_array.sv
// Histogram-equalisation divider array: streams packed CDF words from scratch memory,
// maps every lane through the equalisation divide and writes packed pixels back.
module hist_eq_div_array
    import hist_eq_pkg::*;
#(
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input logic               clk,
    input logic               reset,
    hist_eq_div_array_if.slave bus
);

    localparam int unsigned NumW = calc_num_w(DATA_W, PIX_W);
    localparam int unsigned CntW = $clog2(NumW);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   cdf_min_q, cdf_min_d;
    logic [DATA_W-1:0]   den_q, den_d;
    logic                den_zero_q, den_zero_d;
    logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
    logic [ADDR_W-1:0]   wt_base_q, wt_base_d;
    logic [ADDR_W-1:0]   num_words_q, num_words_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                lane_load;
    logic                lane_step;

    logic [PIX_W-1:0]        lane_pix [LANES];
    logic [LANES*DATA_W-1:0] packed_res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            cdf_min_q   <= '0;
            den_q       <= '0;
            den_zero_q  <= 1'b0;
            rd_base_q   <= '0;
            wt_base_q   <= '0;
            num_words_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cdf_min_q   <= cdf_min_d;
            den_q       <= den_d;
            den_zero_q  <= den_zero_d;
            rd_base_q   <= rd_base_d;
            wt_base_q   <= wt_base_d;
            num_words_q <= num_words_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cdf_min_d   = cdf_min_q;
        den_d       = den_q;
        den_zero_d  = den_zero_q;
        rd_base_d   = rd_base_q;
        wt_base_d   = wt_base_q;
        num_words_d = num_words_q;
        done_d      = 1'b0;
        err_d       = err_q;
        lane_load   = 1'b0;
        lane_step   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    cdf_min_d   = bus.cdf_min;
                    den_d       = bus.total_pix - bus.cdf_min;
                    den_zero_d  = (bus.total_pix == bus.cdf_min);
                    err_d       = (bus.total_pix == bus.cdf_min);
                    rd_base_d   = bus.rd_base;
                    wt_base_d   = bus.wt_base;
                    num_words_d = bus.num_words;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = (bus.num_words == '0) ? StFin : StRd;
                end
            end
            StRd: begin
                state_d = StLoad;
            end
            StLoad: begin
                lane_load = 1'b1;
                cnt_d     = '0;
                // A zero denominator leaves every lane at 0, so the divide is skipped.
                state_d   = den_zero_q ? StWr : StDiv;
            end
            StDiv: begin
                lane_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CntW'(NumW - 1)) begin
                    state_d = StWr;
                end
            end
            StWr: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == num_words_q - ADDR_W'(1)) ? StFin : StRd;
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    for (genvar g = 0; g < LANES; g++) begin : gen_lane
        hist_eq_div_lane #(
            .DATA_W (DATA_W),
            .PIX_W  (PIX_W)
        ) u_lane (
            .clk_i     (clk),
            .rst_ni    (reset),
            .load_i    (lane_load),
            .step_i    (lane_step),
            .zero_i    (den_zero_q),
            .cdf_i     (bus.mem_rd_data[g*DATA_W +: DATA_W]),
            .cdf_min_i (cdf_min_q),
            .den_i     (den_q),
            .result_o  (lane_pix[g])
        );
        assign packed_res[g*DATA_W +: DATA_W] = DATA_W'(lane_pix[g]);
    end

    // Strobes and buses are decoded straight from state so an async reset clears them at once.
    assign bus.mem_rd_en    = (state_q == StRd);
    assign bus.mem_rd_addr  = (state_q == StRd) ? rd_base_q + idx_q : '0;
    assign bus.mem_wt_en    = (state_q == StWr);
    assign bus.mem_wt_addr  = (state_q == StWr) ? wt_base_q + idx_q : '0;
    assign bus.mem_wt_data  = (state_q == StWr) ? packed_res : '0;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = done_q;
    assign bus.div_zero_err = err_q;

endmodule

// File: tb/tb_hist_eq_div_array.sv
// Randomised self-checking bench for hist_eq_div_array against an arithmetic reference model.
module tb_hist_eq_div_array;

    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 16;
    localparam longint      MaxV   = 255;
`ifdef HIST_EQ_DIV_ROUND_EN
    localparam bit          Round  = 1'b1;
    localparam int          NumW   = 25;
`else
    localparam bit          Round  = 1'b0;
    localparam int          NumW   = 24;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hist_eq_div_array_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hist_eq_div_array #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scratch memory: one-cycle read latency, garbage on the data bus when not reading.
    logic [127:0] mem [logic [15:0]];

    function automatic logic [127:0] mem_read(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 128'd0;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= mem_read(bus.mem_rd_addr);
        else bus.mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    logic [15:0]  rd_log[$];
    logic [15:0]  wr_addr_log[$];
    logic [127:0] wr_data_log[$];
    int           dual_cnt = 0;

    always @(negedge clk) begin
        if (bus.mem_rd_en === 1'b1) rd_log.push_back(bus.mem_rd_addr);
        if (bus.mem_wt_en === 1'b1) begin
            wr_addr_log.push_back(bus.mem_wt_addr);
            wr_data_log.push_back(bus.mem_wt_data);
        end
        if (bus.mem_rd_en === 1'b1 && bus.mem_wt_en === 1'b1) dual_cnt++;
    end

    function automatic logic [15:0] ref_pix(input logic [15:0] cdf, input logic [15:0] cmin,
                                            input logic [15:0] total);
        longint den, num, q;
        den = longint'(total) - longint'(cmin);
        if (den < 0) den += 65536;
        if (den == 0 || cdf < cmin) return 16'd0;
        num = (longint'(cdf) - longint'(cmin)) * MaxV;
        if (Round) num += den / 2;
        q = num / den;
        if (q > MaxV) q = MaxV;
        return 16'(q);
    endfunction

    function automatic logic [127:0] ref_word(input logic [127:0] w, input logic [15:0] cmin,
                                              input logic [15:0] total);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = ref_pix(w[i*16 +: 16], cmin, total);
        return r;
    endfunction

    task automatic scramble();
        bus.cdf_min   = 16'($urandom);
        bus.total_pix = 16'($urandom);
        bus.rd_base   = 16'($urandom);
        bus.wt_base   = 16'($urandom);
        bus.num_words = 16'($urandom);
    endtask

    task automatic fill_rand(input logic [15:0] base, input int n, input logic [15:0] total);
        logic [127:0] w;
        int hi;
        hi = int'(total) + int'(total) / 4;
        if (hi > 65535) hi = 65535;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 8; l++) w[l*16 +: 16] = 16'($urandom_range(0, hi));
            mem[16'(base + 16'(i))] = w;
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_eq({pfx, "_busy"}, 128'(bus.busy), 128'd0);
        check_eq({pfx, "_done"}, 128'(bus.done), 128'd0);
        check_eq({pfx, "_err"}, 128'(bus.div_zero_err), 128'd0);
        check_eq({pfx, "_strobes"}, 128'({bus.mem_rd_en, bus.mem_wt_en}), 128'd0);
        check_eq({pfx, "_addrs"}, 128'({bus.mem_rd_addr, bus.mem_wt_addr}), 128'd0);
        check_eq({pfx, "_wdata"}, bus.mem_wt_data, 128'd0);
    endtask

    task automatic run_job(input logic [15:0] cmin, input logic [15:0] total,
                           input logic [15:0] rb, input logic [15:0] wb,
                           input logic [15:0] nw, input bit poke);
        logic [127:0] exp_data[$];
        int rd0, wr0, dual0, cyc, exp_cyc;
        bit zero;
        zero = (total == cmin);
        for (int i = 0; i < int'(nw); i++) begin
            exp_data.push_back(ref_word(mem_read(16'(rb + 16'(i))), cmin, total));
        end
        rd0   = rd_log.size();
        wr0   = wr_addr_log.size();
        dual0 = dual_cnt;

        bus.cdf_min   = cmin;
        bus.total_pix = total;
        bus.rd_base   = rb;
        bus.wt_base   = wb;
        bus.num_words = nw;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
        check_eq("busy_after_start", 128'(bus.busy), 128'd1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 6) begin
                bus.start = 1'b1;
                scramble();
            end else begin
                bus.start = 1'b0;
            end
        end
        exp_cyc = 2 + int'(nw) * (zero ? 3 : NumW + 3);
        check_eq("done_latency", 128'(cyc), 128'(exp_cyc));
        check_eq("busy_at_done", 128'(bus.busy), 128'd0);
        check_eq("div_zero_err", 128'(bus.div_zero_err), 128'(zero));
        check_eq("rd_count", 128'(rd_log.size() - rd0), 128'(nw));
        check_eq("wr_count", 128'(wr_addr_log.size() - wr0), 128'(nw));
        for (int i = 0; i < int'(nw); i++) begin
            if (rd0 + i < rd_log.size())
                check_eq("rd_addr", 128'(rd_log[rd0+i]), 128'(16'(rb + 16'(i))));
            if (wr0 + i < wr_addr_log.size()) begin
                check_eq("wr_addr", 128'(wr_addr_log[wr0+i]), 128'(16'(wb + 16'(i))));
                check_eq("wr_data", wr_data_log[wr0+i], exp_data[i]);
            end
        end
        check_eq("dual_strobe", 128'(dual_cnt - dual0), 128'd0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 128'(bus.done), 128'd0);
    endtask

    initial begin
        logic [127:0] w;
        logic [15:0]  total, cmin, rb, wb, nw;
        int           wr0;

        bus.start = 1'b0;
        scramble();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full-scale CDF lands exactly on MAXV.
        mem[16'h0100] = {8{16'd4096}};
        run_job(16'd16, 16'd4096, 16'h0100, 16'h0200, 16'd1, 1'b0);
        check_eq("all_lanes_255", wr_data_log[$], {8{16'd255}});

        // Midpoint, exact minimum, below-minimum clamp and saturation.
        w = {16'd0, 16'd65535, 16'd17, 16'd3000, 16'd4096, 16'd10, 16'd16, 16'd2056};
        mem[16'h0300] = w;
        run_job(16'd16, 16'd4096, 16'h0300, 16'h0310, 16'd1, 1'b0);
        w = wr_data_log[$];
        check_eq("lane0_mid", 128'(w[15:0]), Round ? 128'd128 : 128'd127);
        check_eq("lane1_at_min", 128'(w[31:16]), 128'd0);
        check_eq("lane2_below_min", 128'(w[47:32]), 128'd0);
        check_eq("lane6_saturate", 128'(w[111:96]), 128'd255);

        // Zero denominator, then a valid job clears the sticky flag.
        fill_rand(16'h0400, 3, 16'd200);
        run_job(16'd100, 16'd100, 16'h0400, 16'h0410, 16'd3, 1'b0);
        fill_rand(16'h0420, 1, 16'd1000);
        run_job(16'd5, 16'd1000, 16'h0420, 16'h0430, 16'd1, 1'b0);

        // Address wrap on both ports.
        fill_rand(16'hFFFF, 2, 16'd2000);
        run_job(16'd3, 16'd2000, 16'hFFFF, 16'hFFFF, 16'd2, 1'b0);

        // Empty job, and a start pulse while busy.
        run_job(16'd1, 16'd500, 16'h0500, 16'h0600, 16'd0, 1'b0);
        fill_rand(16'h0700, 2, 16'd3000);
        run_job(16'd40, 16'd3000, 16'h0700, 16'h0800, 16'd2, 1'b1);

        for (int j = 0; j < 15; j++) begin
            total = 16'($urandom_range(256, 60000));
            cmin  = ($urandom_range(0, 7) == 0) ? total : 16'($urandom_range(0, int'(total) - 1));
            rb    = 16'($urandom);
            wb    = 16'($urandom);
            nw    = 16'($urandom_range(1, 3));
            fill_rand(rb, int'(nw), total);
            run_job(cmin, total, rb, wb, nw, j[0]);
        end

        // Reset in the middle of the second word's divide.
        fill_rand(16'h0900, 4, 16'd4096);
        wr0 = wr_addr_log.size();
        bus.cdf_min   = 16'd16;
        bus.total_pix = 16'd4096;
        bus.rd_base   = 16'h0900;
        bus.wt_base   = 16'h0A00;
        bus.num_words = 16'd4;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        check_eq("busy_before_abort", 128'(bus.busy), 128'd1);
        #2;
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        check_eq("abort_partial_writes", 128'(wr_addr_log.size() - wr0), 128'd1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("busy_after_release", 128'(bus.busy), 128'd0);
        run_job(16'd16, 16'd4096, 16'h0900, 16'h0A00, 16'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
